// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor. One DIGIT-wide ripple-carry slice handles
// DIGIT bits per clock, and the carry is held in a register between digits.
// A WIDTH-bit operation takes NDIG = WIDTH/DIGIT cycles.
//
// Handshake: start is sampled only while busy=0. The done cycle counts as
// idle, so start held high during done launches the next operation with no
// gap. done is a one-cycle pulse. s/co/ovf hold their values until the next
// completion or reset. busy is the decode of the two-state FSM (IDLE/RUN).
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xa;
  logic [WIDTH-1:0] yb;
  logic [WIDTH-1:0] acc;
  logic             carry;

  logic [DIGIT-1:0] xd;
  logic [DIGIT-1:0] yd;
  logic [DIGIT-1:0] sd;
  logic             cr;
  logic             c_msb_in;
  logic [WIDTH-1:0] acc_nxt;

  assign busy = (state == RUN);

  // One digit slice: ripple of DIGIT full adders fed by the carry register.
  // c_msb_in keeps the carry into the top bit of the digit; on the final
  // digit that is the carry into bit WIDTH-1, needed for overflow.
  always_comb begin
    xd       = xa[int'(cnt) * DIGIT +: DIGIT];
    yd       = yb[int'(cnt) * DIGIT +: DIGIT];
    sd       = '0;
    cr       = carry;
    c_msb_in = carry;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb_in = cr;
      sd[i]    = xd[i] ^ yd[i] ^ cr;
      cr       = (xd[i] & yd[i]) | (cr & (xd[i] ^ yd[i]));
    end
    acc_nxt = acc;
    acc_nxt[int'(cnt) * DIGIT +: DIGIT] = sd;
  end

  // FSM and datapath registers. Outputs s/co/ovf only move at completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      xa    <= '0;
      yb    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xa    <= x;
            yb    <= sub ? ~y : y;
            carry <= ci ^ sub;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= cr;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            s     <= acc_nxt;
            co    <= cr;
            ovf   <= c_msb_in ^ cr;
            done  <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
